instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Pipelined RV32I instruction encoder; the inverse of the immediate generator.
- Takes decoded fields (opcode, registers, funct, signed immediate) and packs them into a 32-bit instruction word.
- Range-checks the immediate for the opcode's format.
- Used by the self-test/boot instruction injector ahead of the dual-issue fetch queue; valid/ready on both sides.

Parameters:
- CNT_W, 16, width of the saturating error counter.
- NOP_WORD, 32'h00000013, word emitted when encoding fails (addi x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input fields valid.
- in_ready  out  1  encoder accepts input this cycle.
- in_opcode  in  7  instruction opcode [6:0].
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_funct3  in  3  funct3.
- in_funct7  in  7  funct7; R-type only.
- in_imm  in  32  signed immediate, byte offset for B/J, full value for U.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  downstream accepts.
- out_instr  out  32  encoded instruction.
- out_err  out  1  immediate out of range or unsupported opcode; qualified by out_valid.
- err_count  out  CNT_W  saturating count of errored words accepted downstream.

Behaviour:
- Reset (async, rst=1): out_valid=0, out_instr=0, out_err=0, err_count=0, all stage valids cleared. in_ready reflects the empty pipe. An in-flight word is dropped. Clocked logic resumes on the first clk edge after rst falls.
- Format by opcode:
  - J: 1101111.
  - U: 0110111, 0010111.
  - I: 0000011, 0010011, 1100111.
  - S: 0100011.
  - B: 1100011.
  - R: 0110011.
  - Anything else: error.
- Legal immediates:
  - I, S: -2048..2047.
  - B: -4096..4094, and bit0=0.
  - J: -1048576..1048574, and bit0=0.
  - U: in_imm[11:0]=0.
  - R: immediate ignored, never an error.
- Packing:
  - I: imm[11:0], rs1, f3, rd, op.
  - S: imm[11:5], rs2, rs1, f3, imm[4:0], op.
  - B: imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op.
  - U: imm[31:12], rd, op.
  - J: imm[20], imm[10:1], imm[11], imm[19:12], rd, op.
  - R: f7, rs2, rs1, f3, rd, op.
  - Fields not used by the format are ignored.
- Error: out_instr=NOP_WORD, out_err=1. No truncated encoding is ever emitted.
- Pipeline, two register stages:
  - S1 registers the fields plus the format code and range-check result.
  - S2 registers the packed word and err.
  - Latency: 2 cycles from the in_valid&&in_ready edge to out_valid, with out_ready held high.
  - Throughput: 1 word/cycle.
- Handshake:
  - Transfer on valid&&ready at the rising edge.
  - in_ready = !s1_valid || (!s2_valid || out_ready). Combinational from out_ready, so no bubble on release.
  - While out_valid && !out_ready, out_instr and out_err hold stable. S1 holds if S2 is held.
  - Simultaneous accept and emit in one cycle is legal. No word is lost or duplicated.
  - out_valid never drops without a transfer.
- err_count:
  - Increments when out_valid && out_ready && out_err.
  - Saturates at all-ones.
- Round-trip property: when out_err=0, decoding out_instr with the immediate generator returns in_imm. For U-format the compare is in_imm with low 12 bits zero.

Decomposition:
- Package riscv_isa_pkg:
  - Opcode localparams (OP_JAL, OP_LUI, OP_AUIPC, OP_LOAD, OP_OPIMM, OP_JALR, OP_STORE, OP_BRANCH, OP_OP).
  - Format enum FMT_R/I/S/B/U/J/BAD.
  - NOP constant.
  - Shared with imm_gen.
- Sub-module imm_range_chk: combinational format + immediate -> ok. Instantiated in S1.

Test Plan:
- Single-field cases, each with out_ready=1 and out_err=0:
  - addi: op=0010011, rd=1, rs1=0, f3=0, imm=-1 -> 0xFFF00093, two cycles after accept.
  - beq: op=1100011, rs1=1, rs2=2, f3=0, imm=8 -> 0x00208463.
  - jal: op=1101111, rd=1, imm=2048 -> 0x001000EF.
  - lui: op=0110111, rd=5, imm=0x12345000 -> 0x123452B7.
- Range errors -> out_instr=0x00000013, out_err=1, err_count increments on accept:
  - addi imm=2048.
  - beq imm=7.
  - lui imm=0x00000001.
- Backpressure:
  - Stimulus: stream 4 words, out_ready low for 3 cycles mid-stream.
  - Response: in_ready drops once both stages are full; out_instr stable while stalled; all 4 words delivered in order, none duplicated.
- Reset mid-operation: assert rst asynchronously between edges with two words in flight -> out_valid=0 and err_count=0 immediately; after release the next accepted word emerges 2 cycles later.
- Random round-trip: 10k random legal fields across all formats -> imm_gen(out_instr)==in_imm and out_err=0 every word.
- Saturation: CNT_W=2, 5 errored words -> err_count stops at 3.

Source files
------------

// File: rtl/riscv_isa_pkg.sv
// RV32I opcode constants, instruction format codes and the opcode-to-format
// mapping shared by the instruction encoder and the immediate generator.
package riscv_isa_pkg;

   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_OP     = 7'b0110011;

   // addi x0,x0,0 -- emitted in place of any word that cannot be encoded
   localparam logic [31:0] NOP_INSTR = 32'h00000013;

   typedef enum logic [2:0] {
      FMT_R,
      FMT_I,
      FMT_S,
      FMT_B,
      FMT_U,
      FMT_J,
      FMT_BAD
   } fmt_e;

   // Classify an opcode into its instruction format; unknown opcodes are BAD
   function automatic fmt_e fmt_of(input logic [6:0] op);
      fmt_e f;
      case (op)
         OP_JAL:                      f = FMT_J;
         OP_LUI, OP_AUIPC:            f = FMT_U;
         OP_LOAD, OP_OPIMM, OP_JALR:  f = FMT_I;
         OP_STORE:                    f = FMT_S;
         OP_BRANCH:                   f = FMT_B;
         OP_OP:                       f = FMT_R;
         default:                     f = FMT_BAD;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/imm_range_chk.sv
// Decides whether a signed immediate fits the encodable range of a format.
module imm_range_chk
   import riscv_isa_pkg::*;
(
   input  fmt_e        fmt,
   input  logic [31:0] imm,
   output logic        ok
);

   logic signed [31:0] simm;

   assign simm = $signed(imm);

   // Per-format range and alignment test; BAD formats are never ok
   always_comb begin
      ok = 1'b0;
      case (fmt)
         FMT_I, FMT_S: ok = (simm >= -32'sd2048) && (simm <= 32'sd2047);
         FMT_B:        ok = (simm >= -32'sd4096) && (simm <= 32'sd4094) && !imm[0];
         FMT_J:        ok = (simm >= -32'sd1048576) && (simm <= 32'sd1048574) && !imm[0];
         FMT_U:        ok = (imm[11:0] == 12'd0);
         FMT_R:        ok = 1'b1;
         default:      ok = 1'b0;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage RV32I instruction encoder: stage 1 captures fields, format and
// range result; stage 2 holds the packed word. Valid/ready on both sides.
module instr_encoder
   import riscv_isa_pkg::*;
#(
   parameter int          CNT_W    = 16,
   parameter logic [31:0] NOP_WORD = NOP_INSTR
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [6:0]       in_opcode,
   input  logic [4:0]       in_rd,
   input  logic [4:0]       in_rs1,
   input  logic [4:0]       in_rs2,
   input  logic [2:0]       in_funct3,
   input  logic [6:0]       in_funct7,
   input  logic [31:0]      in_imm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_instr,
   output logic             out_err,
   output logic [CNT_W-1:0] err_count
);

   fmt_e        in_fmt;
   logic        in_ok;
   logic        s2_ready;

   logic        s1_valid;
   logic [6:0]  s1_opcode;
   logic [4:0]  s1_rd;
   logic [4:0]  s1_rs1;
   logic [4:0]  s1_rs2;
   logic [2:0]  s1_funct3;
   logic [6:0]  s1_funct7;
   logic [31:0] s1_imm;
   fmt_e        s1_fmt;
   logic        s1_ok;

   logic [31:0] packed_word;

   logic        s2_valid;
   logic [31:0] s2_instr;
   logic        s2_err;

   assign in_fmt = fmt_of(in_opcode);

   imm_range_chk u_range_chk (
      .fmt (in_fmt),
      .imm (in_imm),
      .ok  (in_ok)
   );

   assign s2_ready  = !s2_valid || out_ready;
   assign in_ready  = !s1_valid || s2_ready;
   assign out_valid = s2_valid;
   assign out_instr = s2_instr;
   assign out_err   = s2_err;

   // Stage 1: capture fields when the stage is empty or draining into stage 2
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_opcode <= '0;
         s1_rd     <= '0;
         s1_rs1    <= '0;
         s1_rs2    <= '0;
         s1_funct3 <= '0;
         s1_funct7 <= '0;
         s1_imm    <= '0;
         s1_fmt    <= FMT_BAD;
         s1_ok     <= 1'b0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_opcode <= in_opcode;
            s1_rd     <= in_rd;
            s1_rs1    <= in_rs1;
            s1_rs2    <= in_rs2;
            s1_funct3 <= in_funct3;
            s1_funct7 <= in_funct7;
            s1_imm    <= in_imm;
            s1_fmt    <= in_fmt;
            s1_ok     <= in_ok;
         end
      end
   end

   // Pack stage-1 fields by format; anything not encodable becomes the NOP
   always_comb begin
      packed_word = NOP_WORD;
      if (s1_ok) begin
         case (s1_fmt)
            FMT_I:   packed_word = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
            FMT_S:   packed_word = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:0], s1_opcode};
            FMT_B:   packed_word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                                    s1_imm[4:1], s1_imm[11], s1_opcode};
            FMT_U:   packed_word = {s1_imm[31:12], s1_rd, s1_opcode};
            FMT_J:   packed_word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
                                    s1_rd, s1_opcode};
            FMT_R:   packed_word = {s1_funct7, s1_rs2, s1_rs1, s1_funct3, s1_rd, s1_opcode};
            default: packed_word = NOP_WORD;
         endcase
      end
   end

   // Stage 2: output register, frozen while downstream stalls
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_instr <= '0;
         s2_err   <= 1'b0;
      end else if (s2_ready) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_instr <= packed_word;
            s2_err   <= !s1_ok;
         end
      end
   end

   // Count errored words as they are handed downstream, sticking at all-ones
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_count <= '0;
      end else if (s2_valid && out_ready && s2_err && (err_count != {CNT_W{1'b1}})) begin
         err_count <= err_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed encodings, range errors,
// backpressure, asynchronous reset, randomized round-trip and saturation.
module tb_instr_encoder;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [6:0]  in_opcode;
   logic [4:0]  in_rd;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [2:0]  in_funct3;
   logic [6:0]  in_funct7;
   logic [31:0] in_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic        out_err;
   logic [15:0] err_count;

   logic        sat_in_ready;
   logic        sat_out_valid;
   logic [31:0] sat_out_instr;
   logic        sat_out_err;
   logic [1:0]  sat_err_count;

   typedef struct {
      logic [6:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
   } word_t;

   word_t       sbq[$];
   word_t       cur;
   int          tests = 0;
   int          failed = 0;
   int          errModel = 0;
   int          delivered = 0;
   bit          lastAcc = 0;
   bit          blockedSeen = 0;
   bit          heldValid = 0;
   logic [31:0] heldInstr;
   logic        heldErr;

   instr_encoder dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_err(out_err), .err_count(err_count)
   );

   instr_encoder #(.CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sat_in_ready),
      .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
      .out_valid(sat_out_valid), .out_ready(out_ready), .out_instr(sat_out_instr),
      .out_err(sat_out_err), .err_count(sat_err_count)
   );

   // Free-running 10-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input word_t w);
      cur       = w;
      in_opcode = w.op;
      in_rd     = w.rd;
      in_rs1    = w.rs1;
      in_rs2    = w.rs2;
      in_funct3 = w.f3;
      in_funct7 = w.f7;
      in_imm    = w.imm;
   endtask

   function automatic word_t mk(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] imm);
      word_t w;
      w.op = op; w.rd = rd; w.rs1 = rs1; w.rs2 = rs2; w.f3 = f3; w.f7 = f7; w.imm = imm;
      return w;
   endfunction

   function automatic byte fmtCode(input logic [6:0] op);
      case (op)
         7'b1101111:                         return "J";
         7'b0110111, 7'b0010111:             return "U";
         7'b0000011, 7'b0010011, 7'b1100111: return "I";
         7'b0100011:                         return "S";
         7'b1100011:                         return "B";
         7'b0110011:                         return "R";
         default:                            return "X";
      endcase
   endfunction

   function automatic bit expLegal(input word_t w);
      int s;
      s = $signed(w.imm);
      case (fmtCode(w.op))
         "I", "S": return (s >= -2048) && (s <= 2047);
         "B":      return (s >= -4096) && (s <= 4094) && (s % 2 == 0);
         "J":      return (s >= -1048576) && (s <= 1048574) && (s % 2 == 0);
         "U":      return (w.imm & 32'h00000FFF) == 32'd0;
         "R":      return 1'b1;
         default:  return 1'b0;
      endcase
   endfunction

   // Immediate generator: recover the signed immediate from an encoded word
   function automatic logic [31:0] decodeImm(input logic [31:0] i, input byte f);
      case (f)
         "I":     return {{20{i[31]}}, i[31:20]};
         "S":     return {{20{i[31]}}, i[31:25], i[11:7]};
         "B":     return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         "U":     return {i[31:12], 12'd0};
         "J":     return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
         default: return 32'd0;
      endcase
   endfunction

   // Opcode/register/funct fields packed as a 32-bit vector, unused ones zeroed
   function automatic logic [31:0] fieldVec(input byte f, input logic [6:0] op, input logic [4:0] rd,
                                            input logic [4:0] rs1, input logic [4:0] rs2,
                                            input logic [2:0] f3, input logic [6:0] f7);
      bit uRd, uRs1, uRs2, uF3, uF7;
      uRd  = (f == "I") || (f == "U") || (f == "J") || (f == "R");
      uRs1 = (f == "I") || (f == "S") || (f == "B") || (f == "R");
      uRs2 = (f == "S") || (f == "B") || (f == "R");
      uF3  = uRs1;
      uF7  = (f == "R");
      return {op, uRd ? rd : 5'd0, uRs1 ? rs1 : 5'd0, uRs2 ? rs2 : 5'd0,
              uF3 ? f3 : 3'd0, uF7 ? f7 : 7'd0};
   endfunction

   task automatic checkWord(input word_t w, input logic [31:0] instr, input logic err);
      byte f;
      bit  legal;
      f = fmtCode(w.op);
      legal = expLegal(w);
      checkOutput("word_err", {31'd0, err}, {31'd0, !legal});
      if (!legal) begin
         errModel++;
         checkOutput("word_nop", instr, 32'h00000013);
      end else begin
         checkOutput("word_fields", fieldVec(f, instr[6:0], instr[11:7], instr[19:15], instr[24:20],
                                             instr[14:12], instr[31:25]),
                     fieldVec(f, w.op, w.rd, w.rs1, w.rs2, w.f3, w.f7));
         if (f != "R") begin
            checkOutput("word_imm", decodeImm(instr, f),
                        (f == "U") ? (w.imm & 32'hFFFFF000) : w.imm);
         end
      end
   endtask

   // One clock of scoreboarded traffic; sampling on the falling edge
   task automatic tick();
      bit emt;
      @(negedge clk);
      lastAcc = in_valid && in_ready;
      emt     = out_valid && out_ready;
      if (heldValid) begin
         checkOutput("stall_valid", {31'd0, out_valid}, 32'd1);
         checkOutput("stall_instr", out_instr, heldInstr);
         checkOutput("stall_err", {31'd0, out_err}, {31'd0, heldErr});
      end
      heldValid = out_valid && !out_ready;
      heldInstr = out_instr;
      heldErr   = out_err;
      if (in_valid && !in_ready) blockedSeen = 1'b1;
      if (emt) begin
         delivered++;
         if (sbq.size() == 0) begin
            checkOutput("unexpected_output", 32'd1, 32'd0);
         end else begin
            checkWord(sbq.pop_front(), out_instr, out_err);
         end
      end
      if (lastAcc) sbq.push_back(cur);
      @(posedge clk);
      #1;
   endtask

   // Send one word into an empty pipe and check the two-edge latency and result
   task automatic sendDirected(input string tag, input word_t w, input logic [31:0] expInstr,
                               input logic expErr);
      applyStimulus(w);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      checkOutput({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput({tag, "_early_valid"}, {31'd0, out_valid}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      checkOutput({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      checkOutput({tag, "_instr"}, out_instr, expInstr);
      checkOutput({tag, "_err"}, {31'd0, out_err}, {31'd0, expErr});
      @(posedge clk);
      #1;
   endtask

   function automatic word_t randWord();
      logic [6:0]  ops [9];
      word_t       w;
      int          k;
      int          m;
      logic [31:0] r;
      ops = '{7'b1101111, 7'b0110111, 7'b0010111, 7'b0000011, 7'b0010011,
              7'b1100111, 7'b0100011, 7'b1100011, 7'b0110011};
      k = $urandom_range(0, 9);
      w.op  = (k < 9) ? ops[k] : 7'($urandom_range(0, 127));
      w.rd  = 5'($urandom_range(0, 31));
      w.rs1 = 5'($urandom_range(0, 31));
      w.rs2 = 5'($urandom_range(0, 31));
      w.f3  = 3'($urandom_range(0, 7));
      w.f7  = 7'($urandom_range(0, 127));
      m = $urandom_range(0, 9);
      r = $urandom;
      case (fmtCode(w.op))
         "I", "S": w.imm = (m == 1) ? (r[0] ? 32'd2047 : -32'sd2048)
                                    : 32'(int'($urandom_range(0, 4095)) - 2048);
         "B":      w.imm = (m == 1) ? (r[0] ? 32'd4094 : -32'sd4096)
                                    : 32'((int'($urandom_range(0, 4095)) - 2048) * 2);
         "J":      w.imm = (m == 1) ? (r[0] ? 32'd1048574 : -32'sd1048576)
                                    : 32'((int'($urandom_range(0, 1048575)) - 524288) * 2);
         "U":      w.imm = r & 32'hFFFFF000;
         default:  w.imm = r;
      endcase
      if (m == 0) w.imm = $urandom;
      return w;
   endfunction

   // Directed sequence followed by randomized traffic
   initial begin
      int sent;
      int errSat;
      word_t bp [4];

      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      applyStimulus(mk(7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0));
      @(posedge clk);
      @(negedge clk);
      checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("rst_out_instr", out_instr, 32'd0);
      checkOutput("rst_out_err", {31'd0, out_err}, 32'd0);
      checkOutput("rst_err_count", {16'd0, err_count}, 32'd0);
      checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;

      sendDirected("addi", mk(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF), 32'hFFF00093, 1'b0);
      sendDirected("beq", mk(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8), 32'h00208463, 1'b0);
      sendDirected("jal", mk(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048), 32'h001000EF, 1'b0);
      sendDirected("lui", mk(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000), 32'h123452B7, 1'b0);
      checkOutput("cnt_after_legal", {16'd0, err_count}, 32'd0);

      sendDirected("addi_range", mk(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048), 32'h00000013, 1'b1);
      checkOutput("cnt_err1", {16'd0, err_count}, 32'd1);
      sendDirected("beq_odd", mk(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd7), 32'h00000013, 1'b1);
      checkOutput("cnt_err2", {16'd0, err_count}, 32'd2);
      sendDirected("lui_low", mk(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1), 32'h00000013, 1'b1);
      checkOutput("cnt_err3", {16'd0, err_count}, 32'd3);

      bp[0] = mk(7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd10);
      bp[1] = mk(7'b0010011, 5'd3, 5'd4, 5'd0, 3'd1, 7'd0, 32'd20);
      bp[2] = mk(7'b0100011, 5'd0, 5'd5, 5'd6, 3'd2, 7'd0, 32'd30);
      bp[3] = mk(7'b0110011, 5'd7, 5'd8, 5'd9, 3'd0, 7'h20, 32'd0);
      sent = 0;
      delivered = 0;
      blockedSeen = 1'b0;
      lastAcc = 1'b0;
      for (int c = 0; c < 40 && (sent < 4 || sbq.size() != 0); c++) begin
         out_ready = !(c >= 2 && c < 5);
         if (sent < 4) begin
            applyStimulus(bp[sent]);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         tick();
         if (lastAcc) sent++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      checkOutput("bp_in_ready_dropped", {31'd0, blockedSeen}, 32'd1);
      checkOutput("bp_delivered", delivered, 32'd4);
      checkOutput("bp_queue_empty", sbq.size(), 32'd0);
      checkOutput("bp_err_count", {16'd0, err_count}, 32'd3);

      out_ready = 1'b0;
      applyStimulus(mk(7'b0010011, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd1));
      in_valid = 1'b1;
      tick();
      applyStimulus(mk(7'b0010011, 5'd2, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2));
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput("inflight_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("inflight_full", {31'd0, in_ready}, 32'd0);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async_rst_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("async_rst_count", {16'd0, err_count}, 32'd0);
      checkOutput("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
      sbq.delete();
      heldValid = 1'b0;
      @(posedge clk);
      #3;
      rst = 1'b0;
      sendDirected("post_rst", mk(7'b0010011, 5'd3, 5'd4, 5'd0, 3'd7, 7'd0, 32'd5), 32'h00527193, 1'b0);

      errModel = 0;
      sent = 0;
      lastAcc = 1'b0;
      in_valid = 1'b0;
      for (int c = 0; c < 60000 && sent < 10000; c++) begin
         if (!in_valid || lastAcc) begin
            if ($urandom_range(0, 9) == 0) begin
               in_valid = 1'b0;
            end else begin
               applyStimulus(randWord());
               in_valid = 1'b1;
            end
         end
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
         if (lastAcc) sent++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 10 && sbq.size() != 0; c++) tick();
      checkOutput("rand_sent", sent, 32'd10000);
      checkOutput("rand_drained", sbq.size(), 32'd0);
      checkOutput("rand_err_count", {16'd0, err_count}, (errModel > 65535) ? 32'd65535 : errModel);
      errSat = (errModel > 3) ? 3 : errModel;
      checkOutput("rand_sat_count", {30'd0, sat_err_count}, errSat);

      rst = 1'b1;
      @(posedge clk);
      #3;
      rst = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         sendDirected("sat", mk(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096), 32'h00000013, 1'b1);
         checkOutput("sat_main_count", {16'd0, err_count}, i);
         checkOutput("sat_small_count", {30'd0, sat_err_count}, (i > 3) ? 3 : i);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
